// File: rtl/toggle_link_pkg.sv
// Definitions shared by both ends of the two-phase toggle request/acknowledge link.
package toggle_link_pkg;

  localparam int TLINK_DATA_W      = 8;
  localparam int TLINK_SYNC_STAGES = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    VALID = 1'b1
  } tlink_state_t;

  // A new word is announced whenever the synchronised level differs from the last accepted one.
  function automatic logic toggle_event(input logic cur_lvl, input logic seen_lvl);
    return cur_lvl ^ seen_lvl;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// N-flop single-bit synchroniser, reset to 0; used on both toggle return paths of the link.
module bit_sync
  import toggle_link_pkg::*;
#(
  parameter int STAGES = TLINK_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the asynchronous level through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/toggle_handshake_rx.sv
// Sink end of the toggle link: detects req_tog flips, presents the word on valid/ready
// and answers each consumed word with a flip of ack_tog.
module toggle_handshake_rx
  import toggle_link_pkg::*;
#(
  parameter int DATA_W      = TLINK_DATA_W,
  parameter int SYNC_STAGES = TLINK_SYNC_STAGES,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_tog,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack_tog,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              proto_err
);

  logic         req_s;
  logic         req_seen;
  logic         req_evt;
  tlink_state_t state_r;
  tlink_state_t state_nxt;
  logic         capture_s;
  logic         consume_s;
  logic         err_s;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk(clk),
    .rst(rst),
    .d  (req_tog),
    .q  (req_s)
  );

  assign req_evt = toggle_event(req_s, req_seen);

  // Next-state and per-edge action decode.
  always_comb begin
    state_nxt = state_r;
    capture_s = 1'b0;
    consume_s = 1'b0;
    err_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_evt) begin
          capture_s = 1'b1;
          state_nxt = VALID;
        end else begin
          state_nxt = IDLE;
        end
      end
      VALID: begin
        // A flip while a word is still held is a sender violation; that new word is dropped.
        if (req_evt) begin
          err_s = 1'b1;
        end else begin
          err_s = 1'b0;
        end
        if (out_ready) begin
          consume_s = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = VALID;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, payload, acknowledge, counter and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      req_seen  <= 1'b0;
      ack_tog   <= 1'b0;
      xfer_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      out_valid <= (state_nxt == VALID);
      if (capture_s) begin
        out_data <= req_data;
      end
      if (capture_s || err_s) begin
        req_seen <= req_s;
      end
      if (consume_s) begin
        ack_tog  <= ~ack_tog;
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
      if (err_s) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/toggle_handshake_rx.md
# toggle_handshake_rx

Receiving end of the two-phase (toggle) request/acknowledge link. The transmitting end flips `req_tog` with a T flip-flop to announce each word. This block synchronises `req_tog`, detects each toggle and captures `req_data`. It presents the word on a valid/ready stream and answers with a toggle on `ack_tog` when the word is consumed. It sits at the sink side of any toggle-signalled link, where `req_tog` may come from an unrelated clock.

## Interface
- `DATA_W`, 8: payload width in bits.
- `SYNC_STAGES`, 2: flops in the `req_tog` synchroniser chain; minimum 2.
- `CNT_W`, 16: width of the transfer counter.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_tog`  in  1  request level; each transition is one word. May be asynchronous to `clk`.
- `req_data`  in  DATA_W  payload; the sender holds it stable from the `req_tog` transition until it sees `ack_tog` transition.
- `ack_tog`  out  1  acknowledge level; flips once per consumed word.
- `out_valid`  out  1  `out_data` holds an unconsumed word.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  DATA_W  captured payload.
- `xfer_cnt`  out  CNT_W  words consumed since reset; wraps modulo 2^CNT_W.
- `proto_err`  out  1  sticky flag: sender toggled again before acknowledge.

## Operation
- Reset values (asynchronous, all registers): `ack_tog`=0, `out_valid`=0, `out_data`=0, `xfer_cnt`=0, `proto_err`=0, synchroniser stages=0, `req_seen`=0.
- Internal signals:
  - `req_s` is the last synchroniser stage.
  - `req_seen` is the last accepted request level.
  - `req_evt` = `req_s` XOR `req_seen`.
- IDLE (`out_valid`=0), when `req_evt`=1, on that edge:
  - capture `req_data` into `out_data`;
  - set `req_seen` to `req_s`;
  - set `out_valid`=1;
  - go to VALID.
- VALID (`out_valid`=1): `out_data` and `out_valid` stay constant until `out_valid`&&`out_ready`. On that edge:
  - flip `ack_tog`;
  - clear `out_valid`;
  - increment `xfer_cnt` (wraps from all-ones to 0);
  - go to IDLE.
- Protocol violation: `req_evt`=1 while in VALID, including the same cycle as the consuming handshake. Response:
  - set `proto_err`=1;
  - set `req_seen` to `req_s` (the new word is discarded);
  - leave `out_data` and `out_valid` unaffected;
  - consume the held word normally.
- `proto_err` clears only on `rst`.
- Two `req_tog` transitions inside one synchroniser window cancel out and are not detected. This is outside the protocol.
- Reset mid-transfer drops any held word. The sender must be reset together with this block so both toggle levels restart at 0.

## Timing
- `req_tog` transition before edge N: `req_s` changes at edge N+SYNC_STAGES−1. Capture and `out_valid`=1 occur at edge N+SYNC_STAGES. Default latency is 2 cycles from sample to valid.
- `out_valid`&&`out_ready` at edge M: `ack_tog` flips, `out_valid` falls and `xfer_cnt` increments, all at edge M. No cycle of added latency.
- Minimum spacing between outputs is one IDLE cycle. A request already pending in `req_s` when returning to IDLE is captured on the next edge.
- `out_ready` may be held high permanently. Each word is then valid for exactly one cycle.
- `req_data` is sampled only at the capture edge. No synchroniser is used on the data; its stability is guaranteed by the protocol.

## Structure
- Shared package `toggle_link_pkg`:
  - state typedef `tlink_state_t` {IDLE, VALID};
  - default constants `TLINK_DATA_W`=8 and `TLINK_SYNC_STAGES`=2, also used by the transmitting end.
- Sub-module `bit_sync`: an N-flop single-bit synchroniser with async active-high reset to 0. It is also reused by the transmitter for the `ack_tog` return path.

## Test plan
- Reset check: assert `rst` with `req_tog`=1 pending, release after 2 cycles -> all outputs 0. The word is captured 2 cycles after release with `xfer_cnt`=0.
- Single transfer: `req_data`=0xA5, toggle `req_tog` 0→1, `out_ready`=1 -> `out_valid` high 2 edges later with `out_data`=0xA5. `ack_tog`=1 on the next edge, `xfer_cnt`=1.
- Backpressure: toggle with `req_data`=0x3C, `out_ready`=0 for 5 cycles -> `out_valid`=1 and `out_data`=0x3C constant and `ack_tog` unchanged for 5 cycles. Raising `out_ready` flips `ack_tog` that edge.
- Protocol violation: toggle twice 4 cycles apart while `out_ready`=0 -> `proto_err`=1 from the second detection and stays 1. Exactly one word (the first) is delivered and `ack_tog` flips once.
- Wrap and throughput: `CNT_W`=4, 17 compliant transfers via a model sender -> `xfer_cnt`=1 at the end. `ack_tog` parity equals 1, no `proto_err`.
- Reset mid-operation: assert `rst` while in VALID holding 0x77 -> `out_valid`=0, `out_data`=0 and `ack_tog`=0 immediately, with no clock edge required.
